// File: rtl/complex_multiplier.sv
// Two-stage pipelined signed complex multiplier producing an exact, full-precision product.
// Stage 1 registers the four partial products, stage 2 registers their sum and difference.
module complex_multiplier #(
    parameter int DATA1_WIDTH = 8,
    parameter int DATA2_WIDTH = 8
) (
    input  logic                                    sys_clk_i,
    input  logic                                    rst_i,
    input  logic signed [DATA1_WIDTH-1:0]           data1_real_i,
    input  logic signed [DATA1_WIDTH-1:0]           data1_imag_i,
    input  logic signed [DATA2_WIDTH-1:0]           data2_real_i,
    input  logic signed [DATA2_WIDTH-1:0]           data2_imag_i,
    output logic signed [DATA1_WIDTH+DATA2_WIDTH:0] data_out_real_o,
    output logic signed [DATA1_WIDTH+DATA2_WIDTH:0] data_out_imag_o
);

    localparam int P = DATA1_WIDTH + DATA2_WIDTH;

    logic signed [P-1:0] ar_ext;
    logic signed [P-1:0] ai_ext;
    logic signed [P-1:0] br_ext;
    logic signed [P-1:0] bi_ext;

    logic signed [P-1:0] prod_rr;
    logic signed [P-1:0] prod_ii;
    logic signed [P-1:0] prod_ri;
    logic signed [P-1:0] prod_ir;

    // Operands are widened to the product width so a P x P multiply keeps the exact P-bit result.
    assign ar_ext = {{DATA2_WIDTH{data1_real_i[DATA1_WIDTH-1]}}, data1_real_i};
    assign ai_ext = {{DATA2_WIDTH{data1_imag_i[DATA1_WIDTH-1]}}, data1_imag_i};
    assign br_ext = {{DATA1_WIDTH{data2_real_i[DATA2_WIDTH-1]}}, data2_real_i};
    assign bi_ext = {{DATA1_WIDTH{data2_imag_i[DATA2_WIDTH-1]}}, data2_imag_i};

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            prod_rr <= '0;
            prod_ii <= '0;
            prod_ri <= '0;
            prod_ir <= '0;
        end else begin
            prod_rr <= ar_ext * br_ext;
            prod_ii <= ai_ext * bi_ext;
            prod_ri <= ar_ext * bi_ext;
            prod_ir <= ai_ext * br_ext;
        end
    end

    // One extra bit absorbs the only growth case: both operands at their most negative values.
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            data_out_real_o <= '0;
            data_out_imag_o <= '0;
        end else begin
            data_out_real_o <= {prod_rr[P-1], prod_rr} - {prod_ii[P-1], prod_ii};
            data_out_imag_o <= {prod_ri[P-1], prod_ri} + {prod_ir[P-1], prod_ir};
        end
    end

endmodule

// File: tb/tb_complex_multiplier.sv
// Scoreboard bench for complex_multiplier: an 8x8 instance and a 10x8 instance driven in lockstep.
// Expected results are queued at issue time and popped by a monitor when a result is due.
module tb_complex_multiplier;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic signed [7:0]  a_ar, a_ai, a_br, a_bi;
    logic signed [16:0] a_re, a_im;
    logic signed [9:0]  b_ar, b_ai;
    logic signed [7:0]  b_br, b_bi;
    logic signed [18:0] b_re, b_im;

    complex_multiplier #(.DATA1_WIDTH(8), .DATA2_WIDTH(8)) dut_a (
        .sys_clk_i       (clk),
        .rst_i           (rst),
        .data1_real_i    (a_ar),
        .data1_imag_i    (a_ai),
        .data2_real_i    (a_br),
        .data2_imag_i    (a_bi),
        .data_out_real_o (a_re),
        .data_out_imag_o (a_im)
    );

    complex_multiplier #(.DATA1_WIDTH(10), .DATA2_WIDTH(8)) dut_b (
        .sys_clk_i       (clk),
        .rst_i           (rst),
        .data1_real_i    (b_ar),
        .data1_imag_i    (b_ai),
        .data2_real_i    (b_br),
        .data2_imag_i    (b_bi),
        .data_out_real_o (b_re),
        .data_out_imag_o (b_im)
    );

    typedef struct {
        int                 tag;
        logic signed [16:0] a_re;
        logic signed [16:0] a_im;
        logic signed [18:0] b_re;
        logic signed [18:0] b_im;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_exp;

    bit issued;
    bit v1, v2, z1, z2;
    int checks;
    int errors;

    function automatic longint cmul_re(input longint ar, input longint ai, input longint br, input longint bi);
        return ar * br - ai * bi;
    endfunction

    function automatic longint cmul_im(input longint ar, input longint ai, input longint br, input longint bi);
        return ar * bi + ai * br;
    endfunction

    function automatic logic signed [7:0] rnd8();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 8'sh80;
        if (sel == 1) return 8'sh7F;
        return 8'($urandom());
    endfunction

    function automatic logic signed [9:0] rnd10();
        int sel;
        sel = $urandom_range(0, 7);
        if (sel == 0) return 10'sh200;
        if (sel == 1) return 10'sh1FF;
        return 10'($urandom());
    endfunction

    task automatic checkOutput(input string what, input int tag,
                               input logic signed [18:0] act, input logic signed [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s tag=%0d actual=%0d expected=%0d", what, tag, act, exp);
        end
    endtask

    // Tracks where issued vectors sit in the two-stage pipe; a reset discards whatever is in flight.
    always @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            z1 <= 1'b1;
            exp_q.delete();
        end else begin
            v1 <= issued;
            v2 <= v1;
            z1 <= 1'b0;
        end
        z2 <= z1;
    end

    always @(negedge clk) begin
        if (z1 || z2) begin
            checkOutput("reset_a_re", 0, a_re, 19'sd0);
            checkOutput("reset_a_im", 0, a_im, 19'sd0);
            checkOutput("reset_b_re", 0, b_re, 19'sd0);
            checkOutput("reset_b_im", 0, b_im, 19'sd0);
        end
        if (v2) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard_empty actual=%0d expected=%0d", 0, 1);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("a_re", mon_exp.tag, a_re, mon_exp.a_re);
                checkOutput("a_im", mon_exp.tag, a_im, mon_exp.a_im);
                checkOutput("b_re", mon_exp.tag, b_re, mon_exp.b_re);
                checkOutput("b_im", mon_exp.tag, b_im, mon_exp.b_im);
            end
        end
    end

    task automatic applyStimulus(input int tag,
                                 input logic signed [7:0] ar, input logic signed [7:0] ai,
                                 input logic signed [7:0] br, input logic signed [7:0] bi,
                                 input longint exp_re, input longint exp_im,
                                 input logic signed [9:0] xr, input logic signed [9:0] xi,
                                 input logic signed [7:0] yr, input logic signed [7:0] yi);
        exp_t e;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        issued = 1'b1;
        a_ar = ar; a_ai = ai; a_br = br; a_bi = bi;
        b_ar = xr; b_ai = xi; b_br = yr; b_bi = yi;
        e.tag  = tag;
        e.a_re = 17'(exp_re);
        e.a_im = 17'(exp_im);
        e.b_re = 19'(cmul_re(xr, xi, yr, yi));
        e.b_im = 19'(cmul_im(xr, xi, yr, yi));
        exp_q.push_back(e);
    endtask

    task automatic applyDirected(input int tag,
                                 input logic signed [7:0] ar, input logic signed [7:0] ai,
                                 input logic signed [7:0] br, input logic signed [7:0] bi,
                                 input longint exp_re, input longint exp_im);
        applyStimulus(tag, ar, ai, br, bi, exp_re, exp_im, ar, ai, br, bi);
    endtask

    task automatic applyRandom(input int tag);
        logic signed [7:0] ar, ai, br, bi;
        ar = rnd8(); ai = rnd8(); br = rnd8(); bi = rnd8();
        applyStimulus(tag, ar, ai, br, bi, cmul_re(ar, ai, br, bi), cmul_im(ar, ai, br, bi),
                      rnd10(), rnd10(), rnd8(), rnd8());
    endtask

    task automatic resetCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst    = 1'b1;
            issued = 1'b0;
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst    = 1'b0;
            issued = 1'b0;
        end
    endtask

    initial begin
        issued = 1'b0;
        a_ar = 8'sd33; a_ai = -8'sd17; a_br = 8'sd64; a_bi = 8'sd5;
        b_ar = 10'sd300; b_ai = -10'sd99; b_br = -8'sd45; b_bi = 8'sd45;
        resetCycles(2);

        applyDirected(1, 8'sd5, -8'sd7, 8'sd64, 8'sd0, 320, -448);
        idleCycles(3);

        // Hand-computed vectors, including the twiddle case and both extreme corners.
        applyDirected(2, 8'sd10, -8'sd3, 8'sd45, -8'sd45, 315, -585);
        applyDirected(3, 8'sh80, 8'sh80, 8'sh80, 8'sh80, 0, 32768);
        applyDirected(4, 8'sh80, 8'sd127, 8'sh80, 8'sh80, 32640, 128);
        applyDirected(5, 8'sd127, 8'sd127, 8'sd127, 8'sd127, 0, 32258);
        applyDirected(6, 8'sd1, 8'sd1, 8'sd0, 8'sd64, -64, 64);
        applyDirected(7, -8'sd1, 8'sd0, -8'sd1, 8'sd0, 1, 0);
        applyDirected(8, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 0, 0);
        idleCycles(3);

        for (int i = 0; i < 20; i++) applyRandom(100 + i);

        for (int i = 0; i < 5; i++) applyRandom(200 + i);
        resetCycles(1);
        for (int i = 0; i < 5; i++) applyRandom(300 + i);

        for (int i = 0; i < 1000; i++) applyRandom(1000 + i);
        idleCycles(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d expected=%0d", exp_q.size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
